// File: rtl/wrapper_sequencer_if.sv
// Handshake bundle between the wrapper sequencer and its datapath/engine/FIFO environment.
// master is the sequencer side; slave is the environment that drives requests and status.
interface wrapper_sequencer_if #(
   parameter int ITER_W = 2
);
   logic              start;
   logic              eng_done;
   logic              full;
   logic              ld;
   logic              ui_ld;
   logic              eng_start;
   logic              wrreq;
   logic              sh_en;
   logic              busy;
   logic              done;
   logic              err;
   logic [ITER_W-1:0] iter_cnt;

   modport master (
      input  start, eng_done, full,
      output ld, ui_ld, eng_start, wrreq, sh_en, busy, done, err, iter_cnt
   );

   modport slave (
      output start, eng_done, full,
      input  ld, ui_ld, eng_start, wrreq, sh_en, busy, done, err, iter_cnt
   );
endinterface

// File: rtl/wrapper_sequencer.sv
// Control FSM for the exponential wrapper: per request, runs the engine N_ITER times,
// shifting the operand between runs and pushing each result into the FIFO; a watchdog aborts hung runs.
module wrapper_sequencer #(
   parameter int N_ITER      = 4,
   parameter int ITER_W      = 2,
   parameter int ENG_TIMEOUT = 255,
   parameter int TMR_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   wrapper_sequencer_if.master bus
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;
   localparam logic [2:0] SHIFT = 3'd5;
   localparam logic [2:0] FIN   = 3'd6;
   localparam logic [2:0] ERR   = 3'd7;

   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ENG_TIMEOUT - 1);

   logic [2:0]        state;
   logic [ITER_W-1:0] iter_cnt;
   logic [TMR_W-1:0]  timer;
   logic              err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         iter_cnt <= '0;
         timer    <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) state <= LOAD;
            end
            LOAD: begin
               iter_cnt <= '0;
               err      <= 1'b0;
               state    <= START;
            end
            START: begin
               timer <= '0;
               state <= WAIT;
            end
            // A completion arriving on the final watchdog cycle still counts as success.
            WAIT: begin
               if (bus.eng_done) begin
                  state <= WRITE;
               end else if (timer == TMR_LAST) begin
                  state <= ERR;
                  err   <= 1'b1;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            WRITE: begin
               if (!bus.full) state <= (iter_cnt == LAST_ITER) ? FIN : SHIFT;
            end
            SHIFT: begin
               iter_cnt <= iter_cnt + ITER_W'(1);
               state    <= START;
            end
            FIN: begin
               state <= IDLE;
            end
            ERR: begin
               if (bus.start) begin
                  state <= LOAD;
                  err   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.ld        = (state == LOAD);
   assign bus.ui_ld     = (state == LOAD);
   assign bus.eng_start = (state == START);
   assign bus.wrreq     = (state == WRITE) && !bus.full;
   assign bus.sh_en     = (state == SHIFT);
   assign bus.busy      = (state != IDLE) && (state != ERR);
   assign bus.done      = (state == FIN);
   assign bus.err       = err;
   assign bus.iter_cnt  = iter_cnt;

endmodule

// File: tb/tb_wrapper_sequencer.sv
// Self-checking bench for wrapper_sequencer: an engine/FIFO responder plus a timing model
// that predicts strobe counts, iteration indices and the completion cycle of each request.
module tb_wrapper_sequencer;

   localparam int N_ITER      = 4;
   localparam int ITER_W      = 2;
   localparam int ENG_TIMEOUT = 255;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fails  = 0;
   int   lat_tab[N_ITER];
   int   stall_tab[N_ITER];

   wrapper_sequencer_if #(.ITER_W(ITER_W)) bus();

   wrapper_sequencer #(
      .N_ITER(N_ITER), .ITER_W(ITER_W), .ENG_TIMEOUT(ENG_TIMEOUT), .TMR_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int strobeSum();
      return int'(bus.ld) + int'(bus.eng_start) + int'(bus.sh_en) + int'(bus.wrreq);
   endfunction

   task automatic setTables(input int lat, input int stall);
      for (int r = 0; r < N_ITER; r++) begin
         lat_tab[r]   = lat;
         stall_tab[r] = stall;
      end
   endtask

   // One request, starting from IDLE or ERR. Completion cycle (start edge = cycle 0):
   // LOAD + per run (START + latency WAIT cycles + WRITE + stall) + SHIFTs between runs + FIN.
   task automatic applyStimulus(input bit noisy, input bit expect_timeout);
      int c = 0, due = -1, write_cyc = -1, full_left = 0, run = 0;
      int n_es = 0, n_wr = 0, n_sh = 0, done_at = -1, exp_done, budget;
      exp_done = 1 + (N_ITER - 1) + 1;
      for (int r = 0; r < N_ITER; r++) exp_done += 2 + lat_tab[r] + stall_tab[r];
      budget = expect_timeout ? (2 + ENG_TIMEOUT + 1) : (exp_done + 8);
      bus.start    = 1'b1;
      bus.eng_done = 1'b0;
      bus.full     = 1'b0;
      while (c < budget) begin
         tick();
         c++;
         checkOutput("ld", bus.ld, c == 1);
         checkOutput("ui_ld", bus.ui_ld, c == 1);
         checkOutput("busy", bus.busy, !(expect_timeout && c == budget));
         checkOutput("err", bus.err, expect_timeout && c == budget);
         if (bus.eng_start) begin
            checkOutput("iter_at_start", bus.iter_cnt, n_es);
            if (n_es == 0) checkOutput("first_eng_start_cycle", c, 2);
            run = n_es;
            due = c + lat_tab[run];
            n_es++;
         end
         if (bus.sh_en) begin
            checkOutput("iter_at_shift", bus.iter_cnt, n_sh);
            n_sh++;
         end
         if (bus.done) done_at = c;

         bus.start = (noisy && !expect_timeout) ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (full_left > 0) begin
            bus.full = 1'b1;
            full_left--;
         end else if (c == write_cyc) begin
            bus.full = 1'b0;
         end else begin
            bus.full = noisy ? ($urandom_range(0, 1) == 1) : 1'b0;
         end
         bus.eng_done = (c == due) || (noisy && bus.eng_start && ($urandom_range(0, 1) == 1));
         if (c == due) begin
            full_left = stall_tab[run];
            write_cyc = due + 1 + stall_tab[run];
         end

         #1;
         if (bus.wrreq) begin
            checkOutput("wrreq_while_full", bus.full, 0);
            checkOutput("wrreq_cycle", c, write_cyc);
            checkOutput("iter_at_wrreq", bus.iter_cnt, n_wr);
            n_wr++;
         end
         checkOutput("strobes_exclusive", strobeSum() <= 1, 1);
         if (done_at >= 0) break;
      end
      bus.start    = 1'b0;
      bus.eng_done = 1'b0;
      bus.full     = 1'b0;
      if (expect_timeout) begin
         checkOutput("timeout_eng_starts", n_es, 1);
         checkOutput("timeout_wrreqs", n_wr, 0);
         checkOutput("timeout_no_done", done_at, -1);
      end else begin
         checkOutput("done_cycle", done_at, exp_done);
         checkOutput("eng_start_count", n_es, N_ITER);
         checkOutput("wrreq_count", n_wr, N_ITER);
         checkOutput("sh_en_count", n_sh, N_ITER - 1);
         tick();
         checkOutput("busy_after_done", bus.busy, 0);
         checkOutput("done_single_pulse", bus.done, 0);
      end
   endtask

   initial begin
      int due = -1, n_es = 0;
      bit fired = 1'b0;

      // Reset with start held high must keep everything quiet.
      rst          = 1'b0;
      bus.start    = 1'b1;
      bus.eng_done = 1'b0;
      bus.full     = 1'b0;
      repeat (3) begin
         tick();
         checkOutput("reset_outputs",
                     {bus.ld, bus.ui_ld, bus.eng_start, bus.wrreq, bus.sh_en,
                      bus.busy, bus.done, bus.err, bus.iter_cnt}, 0);
      end
      bus.start = 1'b0;
      rst       = 1'b1;
      tick();
      checkOutput("idle_after_reset", {bus.busy, bus.done, bus.err}, 0);

      setTables(5, 0);
      applyStimulus(1'b0, 1'b0);

      setTables(5, 0);
      stall_tab[1] = 10;
      applyStimulus(1'b0, 1'b0);

      setTables(100000, 0);
      applyStimulus(1'b0, 1'b1);
      repeat (3) begin
         tick();
         checkOutput("err_sticky", {bus.err, bus.busy, bus.wrreq}, 3'b100);
      end
      setTables(5, 0);
      applyStimulus(1'b0, 1'b0);

      setTables(3, 1);
      lat_tab[0] = ENG_TIMEOUT;
      applyStimulus(1'b1, 1'b0);

      repeat (6) begin
         for (int r = 0; r < N_ITER; r++) begin
            lat_tab[r]   = $urandom_range(1, 8);
            stall_tab[r] = $urandom_range(0, 3);
         end
         applyStimulus(1'b1, 1'b0);
      end

      // Reset asserted in the middle of the second run's wait.
      setTables(5, 0);
      bus.start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         bus.start = 1'b0;
         if (bus.eng_start) begin
            n_es++;
            due = k + 5;
         end
         bus.eng_done = (k == due);
         if (n_es == 2 && k == due - 2) begin
            rst   = 1'b0;
            fired = 1'b1;
            break;
         end
      end
      checkOutput("midrun_reset_reached", fired, 1);
      tick();
      checkOutput("midrun_reset_outputs",
                  {bus.ld, bus.eng_start, bus.wrreq, bus.sh_en, bus.busy, bus.done, bus.iter_cnt}, 0);
      rst          = 1'b1;
      bus.eng_done = 1'b1;
      repeat (6) begin
         tick();
         bus.eng_done = 1'b0;
         checkOutput("post_reset_quiet", {bus.wrreq, bus.done, bus.busy}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
